// File: rtl/telem_frame_mon_if.sv
// rtl/telem_frame_mon_if.sv - byte handshake between a UART receiver and the frame monitor
interface telem_frame_mon_if;
  logic       rdy;
  logic [7:0] rx_data;
  logic       clr_rdy;

  modport master (output rdy, output rx_data, input clr_rdy);
  modport slave  (input rdy, input rx_data, output clr_rdy);
endinterface

// File: rtl/telem_frame_mon.sv
// rtl/telem_frame_mon.sv - telemetry frame parser with checksum, resync, timeout and peak tracking
module telem_frame_mon #(
  parameter int         NUM_CH  = 3,
  parameter int         CH_W    = 12,
  parameter logic [7:0] HDR0    = 8'hAA,
  parameter logic [7:0] HDR1    = 8'h55,
  parameter int         CHK_EN  = 0,
  parameter int         TIMEOUT = 50000
) (
  input  logic                   clk,
  input  logic                   rst,
  telem_frame_mon_if.slave       rx,
  input  logic                   clr_peak,
  output logic [NUM_CH*CH_W-1:0] ch_data,
  output logic [NUM_CH*CH_W-1:0] peak,
  output logic                   frame_vld,
  output logic [15:0]            frame_cnt,
  output logic [7:0]             err_cnt,
  output logic                   in_frame
);
  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [7:0]    PAD_MASK = 8'(16'h00FF << (CH_W - 8));
  localparam logic [3:0]    LAST_IDX = 4'(2 * NUM_CH - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, HDR, PAY, CHK} state_t;

  state_t                        state_q, state_d, cur;
  logic [3:0]                    idx_q, idx_d;
  logic [7:0]                    sum_q, sum_d;
  logic                          bad_q, bad_d;
  logic [TW-1:0]                 tmo_q, tmo_d;
  logic [NUM_CH-1:0][CH_W-1:0]   shadow_q, shadow_d;
  logic                          clr_rdy_q, clr_rdy_d;
  logic [NUM_CH*CH_W-1:0]        ch_data_q, ch_data_d;
  logic [NUM_CH*CH_W-1:0]        peak_q, peak_d;
  logic                          frame_vld_q, frame_vld_d;
  logic [15:0]                   frame_cnt_q, frame_cnt_d;
  logic [7:0]                    err_cnt_q, err_cnt_d;
  logic                          accept, tmo_hit, fin_good, fin_bad, err_inc;

  // Byte accept, frame parsing FSM, timeout and result bookkeeping
  always_comb begin
    accept      = rx.rdy & ~clr_rdy_q;
    tmo_hit     = (state_q != IDLE) && (tmo_q == TMO_LAST);
    // A timeout abandons the frame first, so a byte on that same cycle starts from IDLE
    cur         = tmo_hit ? IDLE : state_q;
    state_d     = cur;
    idx_d       = idx_q;
    sum_d       = sum_q;
    bad_d       = bad_q;
    shadow_d    = shadow_q;
    fin_good    = 1'b0;
    fin_bad     = 1'b0;
    clr_rdy_d   = accept;
    tmo_d       = (state_q == IDLE || tmo_hit || accept) ? '0 : tmo_q + 1'b1;

    if (accept) begin
      case (cur)
        IDLE: begin
          if (rx.rx_data == HDR0) state_d = HDR;
        end
        HDR: begin
          if (rx.rx_data == HDR1) begin
            state_d = PAY;
            idx_d   = '0;
            sum_d   = '0;
            bad_d   = 1'b0;
          end else if (rx.rx_data != HDR0) begin
            state_d = IDLE;
          end
        end
        PAY: begin
          sum_d = sum_q + rx.rx_data;
          idx_d = idx_q + 4'd1;
          for (int c = 0; c < NUM_CH; c++) begin
            if (idx_q == 4'(2 * c))     shadow_d[c][CH_W-1:8] = rx.rx_data[CH_W-9:0];
            if (idx_q == 4'(2 * c + 1)) shadow_d[c][7:0]      = rx.rx_data;
          end
          if (!idx_q[0] && ((rx.rx_data & PAD_MASK) != 8'h00)) bad_d = 1'b1;
          if (idx_q == LAST_IDX) begin
            if (CHK_EN != 0) begin
              state_d = CHK;
            end else begin
              state_d  = IDLE;
              fin_good = ~bad_d;
              fin_bad  = bad_d;
            end
          end
        end
        CHK: begin
          state_d = IDLE;
          if (bad_q || (rx.rx_data != sum_q)) fin_bad = 1'b1;
          else                                 fin_good = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    err_inc     = fin_bad | tmo_hit;
    frame_vld_d = fin_good;
    frame_cnt_d = (fin_good && frame_cnt_q != 16'hFFFF) ? frame_cnt_q + 16'd1 : frame_cnt_q;
    err_cnt_d   = (err_inc && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;

    // Clearing takes effect first so a simultaneous good frame leaves exactly its own values
    ch_data_d = ch_data_q;
    peak_d    = clr_peak ? '0 : peak_q;
    if (fin_good) begin
      for (int c = 0; c < NUM_CH; c++) begin
        ch_data_d[c*CH_W +: CH_W] = shadow_d[c];
        if (shadow_d[c] > peak_d[c*CH_W +: CH_W]) peak_d[c*CH_W +: CH_W] = shadow_d[c];
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      sum_q       <= '0;
      bad_q       <= 1'b0;
      tmo_q       <= '0;
      shadow_q    <= '0;
      clr_rdy_q   <= 1'b0;
      ch_data_q   <= '0;
      peak_q      <= '0;
      frame_vld_q <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      bad_q       <= bad_d;
      tmo_q       <= tmo_d;
      shadow_q    <= shadow_d;
      clr_rdy_q   <= clr_rdy_d;
      ch_data_q   <= ch_data_d;
      peak_q      <= peak_d;
      frame_vld_q <= frame_vld_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign rx.clr_rdy = clr_rdy_q;
  assign ch_data    = ch_data_q;
  assign peak       = peak_q;
  assign frame_vld  = frame_vld_q;
  assign frame_cnt  = frame_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign in_frame   = (state_q != IDLE);
endmodule

// File: tb/tb_telem_frame_mon.sv
// tb/tb_telem_frame_mon.sv - randomized self-checking bench for telem_frame_mon
module tb_telem_frame_mon;
  localparam int TMO = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  telem_frame_mon_if ifa ();
  telem_frame_mon_if ifb ();

  logic        clr_a = 1'b0, clr_b = 1'b0;
  logic [35:0] ch_a, pk_a;
  logic [31:0] ch_b, pk_b;
  logic        vld_a, vld_b, inf_a, inf_b;
  logic [15:0] fc_a, fc_b;
  logic [7:0]  ec_a, ec_b;

  telem_frame_mon #(.NUM_CH(3), .CH_W(12), .HDR0(8'hAA), .HDR1(8'h55), .CHK_EN(0), .TIMEOUT(TMO)) u_a (
    .clk(clk), .rst(rst), .rx(ifa), .clr_peak(clr_a), .ch_data(ch_a), .peak(pk_a),
    .frame_vld(vld_a), .frame_cnt(fc_a), .err_cnt(ec_a), .in_frame(inf_a));

  telem_frame_mon #(.NUM_CH(2), .CH_W(16), .HDR0(8'hAA), .HDR1(8'h55), .CHK_EN(1), .TIMEOUT(TMO)) u_b (
    .clk(clk), .rst(rst), .rx(ifb), .clr_peak(clr_b), .ch_data(ch_b), .peak(pk_b),
    .frame_vld(vld_b), .frame_cnt(fc_b), .err_cnt(ec_b), .in_frame(inf_b));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: channel values, peaks and counters per instance (0 = A, 1 = B)
  logic [15:0] m_ch [2][8];
  logic [15:0] m_pk [2][8];
  int          m_fc [2];
  int          m_ec [2];
  logic [15:0] fv [8];

  int vld_n [2];
  int clr_n [2];
  int sent_n [2];

  always @(negedge clk) begin
    if (rst) begin
      vld_n[0] = 0; vld_n[1] = 0; clr_n[0] = 0; clr_n[1] = 0;
    end else begin
      if (vld_a) vld_n[0] = vld_n[0] + 1;
      if (vld_b) vld_n[1] = vld_n[1] + 1;
      if (ifa.clr_rdy) clr_n[0] = clr_n[0] + 1;
      if (ifb.clr_rdy) clr_n[1] = clr_n[1] + 1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 8; c++) begin m_ch[s][c] = 0; m_pk[s][c] = 0; end
      m_fc[s] = 0; m_ec[s] = 0; sent_n[s] = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b, input int gap, input bit clr_with);
    bit got = 1'b0;
    if (sel == 0) begin ifa.rdy = 1'b1; ifa.rx_data = b; if (clr_with) clr_a = 1'b1; end
    else          begin ifb.rdy = 1'b1; ifb.rx_data = b; if (clr_with) clr_b = 1'b1; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      got = (sel == 0) ? ifa.clr_rdy : ifb.clr_rdy;
    end
    if (!got) check_eq("accept_wait", 64'(got), 64'd1);
    ifa.rdy = 1'b0; ifb.rdy = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    sent_n[sel]++;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_clr(input int sel);
    if (sel == 0) clr_a = 1'b1; else clr_b = 1'b1;
    @(posedge clk); #1;
    clr_a = 1'b0; clr_b = 1'b0;
    for (int c = 0; c < 8; c++) m_pk[sel][c] = 0;
  endtask

  // Frame from fv[]; the model decides the outcome from the frame rules, not from DUT state
  task automatic send_frame(input int sel, input logic [7:0] chk_xor, input bit clr_last);
    int          n  = (sel == 0) ? 3 : 2;
    int          cw = (sel == 0) ? 12 : 16;
    logic [7:0]  q [$];
    logic [7:0]  sum;
    bit          good;
    sum = 8'h00; good = 1'b1;
    q.push_back(8'hAA); q.push_back(8'h55);
    for (int c = 0; c < n; c++) begin
      q.push_back(fv[c][15:8]); q.push_back(fv[c][7:0]);
      sum = sum + fv[c][15:8] + fv[c][7:0];
      if ((32'(fv[c]) >> cw) != 0) good = 1'b0;
    end
    if (sel == 1) begin
      q.push_back(sum ^ chk_xor);
      if (chk_xor != 8'h00) good = 1'b0;
    end
    for (int i = 0; i < q.size(); i++)
      send_byte(sel, q[i], $urandom_range(2, 5), clr_last && (i == q.size() - 1));
    if (clr_last) for (int c = 0; c < 8; c++) m_pk[sel][c] = 0;
    if (good) begin
      for (int c = 0; c < n; c++) begin
        m_ch[sel][c] = fv[c];
        if (fv[c] > m_pk[sel][c]) m_pk[sel][c] = fv[c];
      end
      if (m_fc[sel] < 65535) m_fc[sel]++;
    end else if (m_ec[sel] < 255) begin
      m_ec[sel]++;
    end
  endtask

  task automatic check_model(input int sel, input string tag);
    int          n  = (sel == 0) ? 3 : 2;
    int          cw = (sel == 0) ? 12 : 16;
    logic [63:0] e_ch = 0, e_pk = 0;
    for (int c = 0; c < n; c++) begin
      e_ch = e_ch | (64'(m_ch[sel][c]) << (c * cw));
      e_pk = e_pk | (64'(m_pk[sel][c]) << (c * cw));
    end
    check_eq({tag, ".ch_data"},   (sel == 0) ? 64'(ch_a) : 64'(ch_b), e_ch);
    check_eq({tag, ".peak"},      (sel == 0) ? 64'(pk_a) : 64'(pk_b), e_pk);
    check_eq({tag, ".frame_cnt"}, (sel == 0) ? 64'(fc_a) : 64'(fc_b), 64'(m_fc[sel]));
    check_eq({tag, ".err_cnt"},   (sel == 0) ? 64'(ec_a) : 64'(ec_b), 64'(m_ec[sel]));
    check_eq({tag, ".in_frame"},  (sel == 0) ? 64'(inf_a) : 64'(inf_b), 64'd0);
    check_eq({tag, ".vld_pulses"}, 64'(vld_n[sel]), 64'(m_fc[sel]));
    check_eq({tag, ".clr_rdy_n"},  64'(clr_n[sel]), 64'(sent_n[sel]));
  endtask

  initial begin
    ifa.rdy = 1'b0; ifa.rx_data = 8'h00; ifb.rdy = 1'b0; ifb.rx_data = 8'h00;
    do_reset();
    check_eq("reset.ch_a", 64'(ch_a), 64'd0);
    check_eq("reset.pk_b", 64'(pk_b), 64'd0);
    check_eq("reset.clr_rdy", 64'(ifa.clr_rdy), 64'd0);
    check_model(0, "reset_a");
    check_model(1, "reset_b");

    // Default frame AA 55 0B B8 05 00 01 23
    fv[0] = 16'h0BB8; fv[1] = 16'h0500; fv[2] = 16'h0123;
    send_frame(0, 8'h00, 1'b0);
    check_eq("t1.ch_data", 64'(ch_a), 64'h123500BB8);
    check_eq("t1.peak", 64'(pk_a), 64'h123500BB8);
    check_model(0, "t1");

    // Peak tracking on channel 2
    fv[2] = 16'h00F0; send_frame(0, 8'h00, 1'b0);
    check_eq("t2.peak_hold", 64'(pk_a[35:24]), 64'h123);
    pulse_clr(0);
    check_eq("t2.peak_clr", 64'(pk_a), 64'd0);
    fv[2] = 16'h0050; send_frame(0, 8'h00, 1'b0);
    check_eq("t2.peak_new", 64'(pk_a[35:24]), 64'h050);
    check_model(0, "t2");

    // Junk and header resync, then abandoned header
    send_byte(0, 8'h37, 2, 1'b0); send_byte(0, 8'hAA, 2, 1'b0);
    send_frame(0, 8'h00, 1'b0);
    check_model(0, "t3_resync");
    send_byte(0, 8'hAA, 2, 1'b0); send_byte(0, 8'h12, 2, 1'b0);
    check_model(0, "t3_abandon");

    // Pad bit set in channel 0 MSB, then a valid frame
    fv[0] = 16'h1BB8; send_frame(0, 8'h00, 1'b0);
    check_eq("t4.err_cnt", 64'(ec_a), 64'd1);
    check_model(0, "t4_bad");
    fv[0] = 16'h0BB8; send_frame(0, 8'h00, 1'b0);
    check_model(0, "t4_good");

    // Checksummed 16-bit frame, then a corrupted checksum
    fv[0] = 16'h1234; fv[1] = 16'hABCD; send_frame(1, 8'h00, 1'b0);
    check_eq("t5.ch_data", 64'(ch_b), 64'hABCD1234);
    check_model(1, "t5_good");
    send_frame(1, 8'h01, 1'b0);
    check_model(1, "t5_bad");

    // Timeout after AA 55 0B; in_frame holds until exactly TMO cycles
    send_byte(0, 8'hAA, 2, 1'b0); send_byte(0, 8'h55, 2, 1'b0); send_byte(0, 8'h0B, 0, 1'b0);
    repeat (TMO - 1) begin @(posedge clk); #1; end
    check_eq("t6.in_frame_before", 64'(inf_a), 64'd1);
    @(posedge clk); #1;
    m_ec[0]++;
    check_model(0, "t6_timeout");

    // Byte arriving on the timeout cycle starts a new frame
    send_byte(0, 8'hAA, 2, 1'b0); send_byte(0, 8'h55, 2, 1'b0); send_byte(0, 8'h0B, 0, 1'b0);
    repeat (TMO - 1) begin @(posedge clk); #1; end
    m_ec[0]++;
    fv[0] = 16'h0ABC; fv[1] = 16'h0111; fv[2] = 16'h0222;
    send_frame(0, 8'h00, 1'b0);
    check_model(0, "t6_edge");

    // Reset mid-payload
    send_byte(0, 8'hAA, 2, 1'b0); send_byte(0, 8'h55, 2, 1'b0); send_byte(0, 8'h0B, 2, 1'b0);
    check_eq("t7.in_frame", 64'(inf_a), 64'd1);
    do_reset();
    check_eq("t7.err_cnt", 64'(ec_a), 64'd0);
    check_model(0, "t7");

    // Randomized frames on both instances
    for (int it = 0; it < 60; it++) begin
      int  sel = it % 2;
      bit  bad = ($urandom_range(0, 4) == 0);
      logic [7:0] cx = 8'h00;
      for (int c = 0; c < 3; c++)
        fv[c] = (sel == 0) ? 16'($urandom_range(0, 12'hFFF)) : 16'($urandom);
      if (bad && sel == 0) fv[$urandom_range(0, 2)] |= 16'(1 << $urandom_range(12, 15));
      if (bad && sel == 1) cx = 8'($urandom_range(1, 255));
      if ($urandom_range(0, 2) == 0) send_byte(sel, 8'($urandom_range(0, 8'hA9)), 1, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        send_byte(sel, 8'hAA, 1, 1'b0); send_byte(sel, 8'($urandom_range(0, 8'h54)), 1, 1'b0);
      end
      if ($urandom_range(0, 3) == 0) send_byte(sel, 8'hAA, 1, 1'b0);
      if ($urandom_range(0, 5) == 0) pulse_clr(sel);
      send_frame(sel, cx, ($urandom_range(0, 4) == 0));
      check_model(sel, "rand");
    end

    // Error counter saturation
    do_reset();
    fv[1] = 16'h0001; fv[2] = 16'h0002;
    for (int k = 0; k < 258; k++) begin
      fv[0] = 16'h8000;
      send_frame(0, 8'h00, 1'b0);
    end
    check_eq("sat.err_cnt", 64'(ec_a), 64'hFF);
    check_model(0, "sat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
